// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares a byte-addressed 64-bit data memory between two
// requesters (port 0 = pipeline MEM stage, port 1 = loader/debug). Handles
// byte/half/word/dword loads with sign/zero extension and stores. Sub-dword
// stores are done as read-modify-write of the enclosing aligned dword.
// Misaligned or out-of-range accesses complete with err and never touch memory.
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [63:0] p0_addr,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic [63:0] p0_wdata,
  output logic        p0_done,
  output logic [63:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [63:0] p1_addr,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic [63:0] p1_wdata,
  output logic        p1_done,
  output logic [63:0] p1_rdata,
  output logic        p1_err,
  output logic [63:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        owner_r;
  logic        we_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic [2:0]  off_r;
  logic [63:0] wdata_r;
  logic [63:0] rbuf_r;
  logic        last_grant_r;

  logic        grant_s;
  logic        req_any_s;
  logic        req_we_s;
  logic        req_uns_s;
  logic        req_err_s;
  logic [1:0]  req_size_s;
  logic [63:0] req_addr_s;
  logic [63:0] req_wdata_s;
  logic [63:0] load_val_s;

  // Misaligned, or last byte lands at/after MEM_BYTES. 65-bit sum so huge
  // addresses cannot wrap back into range.
  function automatic logic access_err(input logic [63:0] addr, input logic [1:0] size);
    logic [2:0]  align_mask;
    logic [64:0] end_addr;
    align_mask = 3'((4'd1 << size) - 4'd1);
    end_addr   = {1'b0, addr} + (65'd1 << size);
    return ((addr[2:0] & align_mask) != 3'd0) || (end_addr > 65'(MEM_BYTES));
  endfunction

  // Pick the addressed bytes out of a dword and extend them to 64 bits.
  function automatic logic [63:0] load_extract(input logic [63:0] dword, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = dword >> {off, 3'b000};
    case (size)
      2'd0:    return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // Replace bytes [off +: 1<<size] of old with the low bytes of wd.
  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] mask;
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (old & ~(mask << {off, 3'b000})) | ((wd & mask) << {off, 3'b000});
  endfunction

  // Arbitration: round-robin against the last served port, or port 0 first.
  always_comb begin
    req_any_s = p0_req | p1_req;
    if (p0_req && p1_req) begin
      if (RR_EN) begin
        grant_s = ~last_grant_r;
      end else begin
        grant_s = 1'b0;
      end
    end else if (p1_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Route the granted port's request fields.
  always_comb begin
    if (grant_s) begin
      req_we_s    = p1_we;
      req_addr_s  = p1_addr;
      req_size_s  = p1_size;
      req_uns_s   = p1_unsigned;
      req_wdata_s = p1_wdata;
    end else begin
      req_we_s    = p0_we;
      req_addr_s  = p0_addr;
      req_size_s  = p0_size;
      req_uns_s   = p0_unsigned;
      req_wdata_s = p0_wdata;
    end
    req_err_s  = access_err(req_addr_s, req_size_s);
    load_val_s = load_extract(mem_rdata, off_r, size_r, uns_r);
  end

  // Write data: full dword for dword stores, otherwise the merged read buffer.
  always_comb begin
    if (state_r == ST_WRITE) begin
      mem_wdata = store_merge(rbuf_r, wdata_r, off_r, size_r);
    end else begin
      mem_wdata = 64'd0;
    end
  end

  // Transaction FSM with registered strobes and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      size_r       <= 2'd0;
      off_r        <= 3'd0;
      wdata_r      <= 64'd0;
      rbuf_r       <= 64'd0;
      last_grant_r <= 1'b1;
      mem_addr     <= 64'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      p0_done      <= 1'b0;
      p0_rdata     <= 64'd0;
      p0_err       <= 1'b0;
      p1_done      <= 1'b0;
      p1_rdata     <= 64'd0;
      p1_err       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            owner_r  <= grant_s;
            we_r     <= req_we_s;
            uns_r    <= req_uns_s;
            size_r   <= req_size_s;
            off_r    <= req_addr_s[2:0];
            wdata_r  <= req_wdata_s;
            mem_addr <= {req_addr_s[63:3], 3'b000};
            if (req_err_s) begin
              state_r <= ST_DONE;
              p0_done <= ~grant_s;
              p0_err  <= ~grant_s;
              p1_done <= grant_s;
              p1_err  <= grant_s;
            end else if (req_we_s && (req_size_s == 2'd3)) begin
              state_r   <= ST_WRITE;
              mem_write <= 1'b1;
            end else begin
              state_r  <= ST_READ;
              mem_read <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          mem_read <= 1'b0;
          rbuf_r   <= mem_rdata;
          if (we_r) begin
            state_r   <= ST_WRITE;
            mem_write <= 1'b1;
          end else begin
            state_r  <= ST_DONE;
            p0_done  <= ~owner_r;
            p1_done  <= owner_r;
            p0_rdata <= owner_r ? 64'd0 : load_val_s;
            p1_rdata <= owner_r ? load_val_s : 64'd0;
          end
        end
        ST_WRITE: begin
          mem_write <= 1'b0;
          state_r   <= ST_DONE;
          p0_done   <= ~owner_r;
          p1_done   <= owner_r;
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          last_grant_r <= owner_r;
          p0_done      <= 1'b0;
          p0_rdata     <= 64'd0;
          p0_err       <= 1'b0;
          p1_done      <= 1'b0;
          p1_rdata     <= 64'd0;
          p1_err       <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: random and directed transactions against a byte-array
// reference model; a second instance covers fixed-priority arbitration.
module tb_dmem_access_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int NDW       = MEM_BYTES / 8;

  logic clk = 1'b0;
  logic reset;

  logic        p0_req, p0_we, p0_unsigned, p1_req, p1_we, p1_unsigned;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [1:0]  p0_size, p1_size;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic        q0_req, q1_req;
  logic        q0_done, q1_done, q0_err, q1_err;
  logic [63:0] q0_rdata, q1_rdata, qm_addr, qm_wdata, qm_rdata;
  logic        qm_read, qm_write;

  logic [63:0] mem_a [NDW];
  logic [63:0] mem_b [NDW];
  logic [63:0] init_dw [NDW];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        init_en;
  logic [6:0]  init_idx;
  logic [63:0] init_data;
  logic        model_last;

  int n_checks = 0;
  int n_errors = 0;

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .RR_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
    .p0_unsigned(p0_unsigned), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
    .p1_unsigned(p1_unsigned), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .RR_EN(1'b0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .p0_req(q0_req), .p0_we(1'b0), .p0_addr(64'h40), .p0_size(2'd3),
    .p0_unsigned(1'b0), .p0_wdata(64'd0),
    .p0_done(q0_done), .p0_rdata(q0_rdata), .p0_err(q0_err),
    .p1_req(q1_req), .p1_we(1'b0), .p1_addr(64'h40), .p1_size(2'd3),
    .p1_unsigned(1'b0), .p1_wdata(64'd0),
    .p1_done(q1_done), .p1_rdata(q1_rdata), .p1_err(q1_err),
    .mem_addr(qm_addr), .mem_read(qm_read), .mem_write(qm_write),
    .mem_wdata(qm_wdata), .mem_rdata(qm_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_a[mem_addr[9:3]];
  assign qm_rdata  = mem_b[qm_addr[9:3]];

  // Memories: loaded during reset, then written by the controllers.
  always @(posedge clk) begin
    if (init_en) begin
      mem_a[init_idx] <= init_data;
      mem_b[init_idx] <= init_data;
    end else begin
      if (mem_write) mem_a[mem_addr[9:3]] <= mem_wdata;
      if (qm_write)  mem_b[qm_addr[9:3]]  <= qm_wdata;
    end
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int a, input int n, input logic uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
    if (!uns && n < 8 && v[8*n-1]) begin
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic drive_port(input int port, input logic req, input logic we, input logic [63:0] addr,
                            input logic [1:0] size, input logic uns, input logic [63:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_unsigned = uns; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_unsigned = uns; p1_wdata = wdata;
    end
  endtask

  // One transaction on one port, checked for result, latency and strobes.
  task automatic txn_check(input int port, input logic we, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata, output logic [63:0] obs);
    int n, a, lat, nrd, nwr, exp_lat, exp_nrd, exp_nwr;
    logic exp_err, got, er, other_seen, both_seen, addr_bad;
    logic [63:0] exp_rd, rd;
    n = 1 << size;
    exp_err = ((addr & 64'(n - 1)) != 64'd0) || (addr > 64'(MEM_BYTES - n));
    a = int'(addr[9:0]);
    exp_rd = (exp_err || we) ? 64'd0 : model_load(a, n, uns);
    if (exp_err)          begin exp_lat = 1; exp_nrd = 0; exp_nwr = 0; end
    else if (we && n == 8) begin exp_lat = 2; exp_nrd = 0; exp_nwr = 1; end
    else if (we)          begin exp_lat = 3; exp_nrd = 1; exp_nwr = 1; end
    else                  begin exp_lat = 2; exp_nrd = 1; exp_nwr = 0; end
    @(negedge clk);
    drive_port(port, 1'b1, we, addr, size, uns, wdata);
    lat = 0; nrd = 0; nwr = 0; got = 1'b0; er = 1'b0; rd = 64'd0;
    other_seen = 1'b0; both_seen = 1'b0; addr_bad = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read && mem_write) both_seen = 1'b1;
      if ((mem_read || mem_write) && mem_addr != {addr[63:3], 3'b000}) addr_bad = 1'b1;
      if ((port == 0) ? p1_done : p0_done) other_seen = 1'b1;
      if ((port == 0) ? p0_done : p1_done) begin
        got = 1'b1;
        rd  = (port == 0) ? p0_rdata : p1_rdata;
        er  = (port == 0) ? p0_err : p1_err;
      end
    end
    drive_port(port, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
    check_value("done_seen", 64'(got), 64'd1);
    check_value("latency", 64'(lat), 64'(exp_lat));
    check_value("read_cycles", 64'(nrd), 64'(exp_nrd));
    check_value("write_cycles", 64'(nwr), 64'(exp_nwr));
    check_value("err", 64'(er), 64'(exp_err));
    check_value("rdata", rd, exp_rd);
    check_value("other_port_done", 64'(other_seen), 64'd0);
    check_value("strobe_overlap", 64'(both_seen), 64'd0);
    check_value("mem_addr", 64'(addr_bad), 64'd0);
    if (got) model_last = 1'(port);
    if (got && we && !exp_err) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
    end
    @(posedge clk); #1;
    check_value("idle_outputs", {p0_rdata | p1_rdata}, 64'd0);
    check_value("idle_done", {62'd0, p0_done, p1_done}, 64'd0);
    obs = rd;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    model_last = 1'b1;
  endtask

  // Both ports held on the round-robin instance.
  task automatic arb_rr(input int count);
    int waited, exp_port;
    logic [63:0] rd;
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 64'h40, 2'd3, 1'b0, 64'd0);
    drive_port(1, 1'b1, 1'b0, 64'h48, 2'd3, 1'b0, 64'd0);
    for (int k = 0; k < count; k++) begin
      exp_port = model_last ? 0 : 1;
      waited = 0;
      while (!(p0_done || p1_done) && waited < 8) begin @(posedge clk); #1; waited++; end
      check_value("rr_done_seen", 64'(p0_done | p1_done), 64'd1);
      check_value("rr_grant", 64'(p1_done), 64'(exp_port));
      check_value("rr_single", 64'(p0_done & p1_done), 64'd0);
      rd = p1_done ? p1_rdata : p0_rdata;
      check_value("rr_rdata", rd, model_load((exp_port == 1) ? 'h48 : 'h40, 8, 1'b0));
      model_last = p1_done;
      if (k == count - 1) begin
        drive_port(0, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
        drive_port(1, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  // Both ports held on the fixed-priority instance, then port 1 alone.
  task automatic arb_fp();
    int waited;
    @(negedge clk);
    q0_req = 1'b1; q1_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (!(q0_done || q1_done) && waited < 8) begin
        @(posedge clk); #1; waited++;
        check_value("fp_strobe_overlap", 64'(qm_read & qm_write), 64'd0);
      end
      check_value("fp_grant_p0", 64'(q0_done), 64'd1);
      check_value("fp_no_p1", 64'(q1_done), 64'd0);
      check_value("fp_rdata", q0_rdata, init_dw[8]);
      check_value("fp_err", 64'(q0_err), 64'd0);
      if (k == 2) q0_req = 1'b0;
      @(posedge clk); #1;
    end
    waited = 0;
    while (!q1_done && waited < 8) begin @(posedge clk); #1; waited++; end
    check_value("fp_p1_alone", 64'(q1_done), 64'd1);
    check_value("fp_p1_rdata", q1_rdata, init_dw[8]);
    check_value("fp_p1_err", 64'(q1_err), 64'd0);
    q1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rd, addr, wdata, exp_dw;
    logic        we, uns;
    logic [1:0]  size;
    int          port, mode, n;

    reset = 1'b1; init_en = 1'b1; init_idx = 7'd0; init_data = 64'd0;
    q0_req = 1'b0; q1_req = 1'b0; model_last = 1'b1;
    drive_port(0, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
    drive_port(1, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);

    for (int i = 0; i < NDW; i++) begin
      @(negedge clk);
      init_idx  = 7'(i);
      init_data = {$urandom, $urandom};
      init_dw[i] = init_data;
      for (int b = 0; b < 8; b++) ref_mem[8*i + b] = init_data[8*b +: 8];
    end
    @(negedge clk);
    init_en = 1'b0;

    check_value("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check_value("rst_done_err", {60'd0, p0_done, p0_err, p1_done, p1_err}, 64'd0);
    check_value("rst_rdata", p0_rdata | p1_rdata, 64'd0);
    check_value("rst_mem_addr", mem_addr, 64'd0);
    check_value("rst_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;

    // Directed sequence.
    txn_check(0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, rd);
    txn_check(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, rd);
    check_value("t1_ld", rd, 64'h1122334455667788);
    txn_check(0, 1'b1, 64'h13, 2'd0, 1'b0, 64'h00000000000000AB, rd);
    txn_check(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, rd);
    check_value("t2_ld", rd, 64'h11223344AB667788);
    txn_check(0, 1'b0, 64'h13, 2'd0, 1'b0, 64'd0, rd);
    check_value("t3_lb", rd, 64'hFFFFFFFFFFFFFFAB);
    txn_check(0, 1'b0, 64'h13, 2'd0, 1'b1, 64'd0, rd);
    check_value("t3_lbu", rd, 64'h00000000000000AB);
    txn_check(0, 1'b0, 64'h12, 2'd1, 1'b0, 64'd0, rd);
    check_value("t3_lh", rd, 64'hFFFFFFFFFFFFAB66);
    txn_check(0, 1'b0, 64'h10, 2'd2, 1'b1, 64'd0, rd);
    check_value("t3_lwu", rd, 64'h00000000AB667788);
    txn_check(0, 1'b0, 64'h12, 2'd2, 1'b0, 64'd0, rd);
    check_value("t4_lw_mis", rd, 64'd0);
    txn_check(1, 1'b1, 64'h3FC, 2'd3, 1'b0, 64'hDEADBEEF, rd);
    txn_check(1, 1'b1, 64'h400, 2'd3, 1'b0, 64'hDEADBEEF, rd);
    txn_check(1, 1'b0, 64'h3F8, 2'd3, 1'b0, 64'd0, rd);
    txn_check(1, 1'b0, 64'h3FF, 2'd0, 1'b0, 64'd0, rd);
    txn_check(1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 2'd3, 1'b0, 64'd0, rd);

    // Random traffic, one port at a time.
    for (int t = 0; t < 300; t++) begin
      port  = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      mode  = int'($urandom_range(0, 9));
      n     = 1 << size;
      if (mode < 7)      addr = 64'($urandom_range(0, MEM_BYTES - 1)) & ~64'(n - 1);
      else if (mode < 9) addr = 64'($urandom_range(0, MEM_BYTES + 64));
      else               addr = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      txn_check(port, we, addr, size, uns, wdata, rd);
    end

    // Arbitration.
    apply_reset();
    arb_rr(4);
    arb_fp();

    // Reset in the middle of a sub-dword store's write cycle.
    @(negedge clk);
    drive_port(0, 1'b1, 1'b1, 64'h20, 2'd0, 1'b0, 64'h00000000000000CD);
    @(posedge clk); #1;
    check_value("rmw_read_phase", 64'(mem_read), 64'd1);
    @(posedge clk); #1;
    check_value("rmw_write_phase", 64'(mem_write), 64'd1);
    reset = 1'b1;
    #1;
    check_value("rst_write_drop", 64'(mem_write), 64'd0);
    check_value("rst_no_done", 64'(p0_done), 64'd0);
    @(negedge clk);
    drive_port(0, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
    exp_dw = model_load('h20, 8, 1'b0);
    check_value("rst_dword_kept", mem_a[4], exp_dw);
    @(posedge clk); #1;
    check_value("rst_after_done", 64'(p0_done), 64'd0);
    txn_check(0, 1'b0, 64'h20, 2'd3, 1'b0, 64'd0, rd);
    check_value("rst_reload", rd, exp_dw);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
